// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM states,
// PC source encodings and the hard-wired zero register.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_LD_STALL = 2'b10,
        ST_FLUSH    = 2'b11
    } state_t;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [2:0] REG_ZERO = 3'd0;

    // The reserved encoding 11 falls through to sequential fetch.
    function automatic logic is_redirect(input logic [1:0] pc_src);
        return (pc_src == PC_SRC_BRANCH) || (pc_src == PC_SRC_JUMP);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register
// a load in EX is about to write. Shared with the forwarding unit.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [2:0] i_id_rs,
    input  logic [2:0] i_id_rt,
    input  logic       i_id_uses_rt,
    input  logic [2:0] i_ex_reg_write,
    input  logic       i_ex_mem_read,
    input  logic       i_ex_wb_reg_write,
    output logic       o_luse
);

    logic w_rs_match;
    logic w_rt_match;
    logic w_ex_load_live;

    // Register 0 is hard-wired, so a load targeting it can never create a hazard.
    assign w_ex_load_live = i_ex_mem_read & i_ex_wb_reg_write & (i_ex_reg_write != REG_ZERO);
    assign w_rs_match     = (i_ex_reg_write == i_id_rs);
    assign w_rt_match     = i_id_uses_rt & (i_ex_reg_write == i_id_rt);
    assign o_luse         = w_ex_load_live & (w_rs_match | w_rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: resolves memory wait, branch/jump redirect and
// load-use hazards into stage enables and bubble strobes, plus perf counters.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       id_rs,
    input  logic [2:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [2:0]       ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_wb_reg_write_signal,
    input  logic [1:0]       mem_pc_src,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       pc_sel,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic             w_luse_raw;
    logic             w_luse;
    logic             w_wait;
    logic             w_redir;
    logic             w_redir_fire;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;

    hazard_detect u_hazard (
        .i_id_rs           (id_rs),
        .i_id_rt           (id_rt),
        .i_id_uses_rt      (id_uses_rt),
        .i_ex_reg_write    (ex_reg_write),
        .i_ex_mem_read     (ex_mem_read),
        .i_ex_wb_reg_write (ex_wb_reg_write_signal),
        .o_luse            (w_luse_raw)
    );

    // While parked in MEM_WAIT the stall is released only by dmem_ready;
    // after LD_STALL/FLUSH the EX slot holds a bubble, so load-use cannot fire.
    assign w_wait  = (r_state == ST_MEM_WAIT) ? ~dmem_ready : (mem_access & ~dmem_ready);
    assign w_redir = is_redirect(mem_pc_src);
    assign w_luse  = w_luse_raw & ((r_state == ST_RUN) || (r_state == ST_MEM_WAIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        exmem_write  = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        pc_sel       = PC_SRC_SEQ;
        w_redir_fire = 1'b0;
        w_next       = ST_RUN;
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (w_wait) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            w_next      = ST_MEM_WAIT;
        end else if (w_redir) begin
            pc_sel       = mem_pc_src;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_flush  = 1'b1;
            w_redir_fire = 1'b1;
            w_next       = ST_FLUSH;
        end else if (w_luse) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            w_next     = ST_LD_STALL;
        end
    end

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (!pc_write && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_ONE;
            end
            if (w_redir_fire && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + CNT_ONE;
            end
        end
    end

    assign state       = r_state;
    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: each cycle's expected controls, state and
// counters are queued as stimulus is driven and popped when sampled.
module tb_pipeline_ctrl;

    import pipe_ctrl_pkg::*;

    typedef struct packed {
        logic [2:0] rs;
        logic [2:0] rt;
        logic       uses_rt;
        logic [2:0] exd;
        logic       mr;
        logic       wb;
        logic [1:0] src;
        logic       acc;
        logic       rdy;
    } stim_t;

    typedef struct {
        logic [8:0]  ctl;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    // Control vector: {pc_write, ifid_write, idex_write, exmem_write,
    //                  ifid_flush, idex_flush, exmem_flush, pc_sel}
    localparam logic [8:0] C_RUN  = 9'b1111_000_00;
    localparam logic [8:0] C_HOLD = 9'b0000_000_00;
    localparam logic [8:0] C_LUSE = 9'b0011_010_00;
    localparam logic [8:0] C_RST  = 9'b0000_111_00;
    localparam logic [8:0] C_BR   = 9'b1111_111_01;
    localparam logic [8:0] C_JMP  = 9'b1111_111_10;

    localparam logic [1:0] S_RUN = 2'b00;
    localparam logic [1:0] S_MW  = 2'b01;
    localparam logic [1:0] S_LS  = 2'b10;
    localparam logic [1:0] S_FL  = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  id_rs, id_rt, ex_reg_write;
    logic        id_uses_rt, ex_mem_read, ex_wb_reg_write_signal;
    logic [1:0]  mem_pc_src;
    logic        mem_access, dmem_ready;

    logic        pc_write, ifid_write, idex_write, exmem_write;
    logic        ifid_flush, idex_flush, exmem_flush;
    logic [1:0]  pc_sel, state;
    logic [15:0] stall_count, flush_count;

    logic        s_pc_write, s_ifid_write, s_idex_write, s_exmem_write;
    logic        s_ifid_flush, s_idex_flush, s_exmem_flush;
    logic [1:0]  s_pc_sel, s_state;
    logic [3:0]  s_stall_count, s_flush_count;

    logic [8:0]  w_obs;
    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          m_stall = 0;
    int          m_flush = 0;
    int          m_stall4 = 0;

    always #5 clk = ~clk;

    assign w_obs = {pc_write, ifid_write, idex_write, exmem_write,
                    ifid_flush, idex_flush, exmem_flush, pc_sel};

    pipeline_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_wb_reg_write_signal(ex_wb_reg_write_signal),
        .mem_pc_src(mem_pc_src), .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
        .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .pc_sel(pc_sel), .state(state),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    pipeline_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_wb_reg_write_signal(ex_wb_reg_write_signal),
        .mem_pc_src(mem_pc_src), .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write), .idex_write(s_idex_write),
        .exmem_write(s_exmem_write), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
        .exmem_flush(s_exmem_flush), .pc_sel(s_pc_sel), .state(s_state),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    function automatic stim_t mk(input logic [2:0] rs, input logic [2:0] rt, input logic uses,
                                 input logic [2:0] exd, input logic mr, input logic wb,
                                 input logic [1:0] src, input logic acc, input logic rdy);
        stim_t s;
        s = '{rs: rs, rt: rt, uses_rt: uses, exd: exd, mr: mr, wb: wb,
              src: src, acc: acc, rdy: rdy};
        return s;
    endfunction

    // Drives one cycle of inputs after the rising edge, queues what the
    // outputs must show at the following falling edge, and advances the model.
    task automatic drive_push(input stim_t s, input logic [8:0] c, input logic [1:0] st);
        exp_t e;
        @(posedge clk);
        #1;
        id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.uses_rt;
        ex_reg_write = s.exd; ex_mem_read = s.mr; ex_wb_reg_write_signal = s.wb;
        mem_pc_src = s.src; mem_access = s.acc; dmem_ready = s.rdy;
        e.ctl = c; e.st = st; e.sc = 16'(m_stall); e.fc = 16'(m_flush);
        exp_q.push_back(e);
        if (!c[8]) begin
            m_stall++;
            if (m_stall4 < 15) m_stall4++;
        end
        if (c[8] && c[2]) m_flush++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        #3;
        total++;
        if ({w_obs, state, stall_count, flush_count} !== {C_RST, S_RUN, 16'd0, 16'd0}) begin
            bad++;
            $display("[TB] FAIL reset_init: got ctl=%b st=%0d sc=%0d fc=%0d, want ctl=%b st=0 sc=0 fc=0",
                     w_obs, state, stall_count, flush_count, C_RST);
        end
        #9;
        rst = 1'b0;
    endtask

    task automatic drive_idle();
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_reg_write = '0;
        ex_mem_read = 1'b0; ex_wb_reg_write_signal = 1'b0;
        mem_pc_src = 2'b00; mem_access = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic test_load_use();
        stim_t s[8]; logic [8:0] c[8]; logic [1:0] st[8]; exp_t e;
        s[0] = mk(3, 0, 0, 3, 1, 1, 0, 0, 1); c[0] = C_LUSE; st[0] = S_RUN;
        s[1] = mk(3, 0, 0, 3, 1, 1, 0, 0, 1); c[1] = C_RUN;  st[1] = S_LS;
        s[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1); c[2] = C_RUN;  st[2] = S_RUN;
        s[3] = mk(5, 3, 1, 3, 1, 1, 0, 0, 1); c[3] = C_LUSE; st[3] = S_RUN;
        s[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1); c[4] = C_RUN;  st[4] = S_LS;
        s[5] = mk(5, 3, 0, 3, 1, 1, 0, 0, 1); c[5] = C_RUN;  st[5] = S_RUN;
        s[6] = mk(0, 0, 0, 0, 1, 1, 0, 0, 1); c[6] = C_RUN;  st[6] = S_RUN;
        s[7] = mk(3, 0, 0, 3, 1, 0, 0, 0, 1); c[7] = C_RUN;  st[7] = S_RUN;
        for (int i = 0; i < 8; i++) begin
            drive_push(s[i], c[i], st[i]);
            e = exp_q.pop_front();
            total++;
            if ({w_obs, state, stall_count, flush_count} !== {e.ctl, e.st, e.sc, e.fc}) begin
                bad++;
                $display("[TB] FAIL load_use[%0d]: got ctl=%b st=%0d sc=%0d fc=%0d, want ctl=%b st=%0d sc=%0d fc=%0d",
                         i, w_obs, state, stall_count, flush_count, e.ctl, e.st, e.sc, e.fc);
            end
        end
    endtask

    task automatic test_branch();
        stim_t s[8]; logic [8:0] c[8]; logic [1:0] st[8]; exp_t e;
        s[0] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1); c[0] = C_BR;  st[0] = S_RUN;
        s[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1); c[1] = C_RUN; st[1] = S_FL;
        s[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1); c[2] = C_RUN; st[2] = S_RUN;
        s[3] = mk(0, 0, 0, 0, 0, 0, 3, 0, 1); c[3] = C_RUN; st[3] = S_RUN;
        s[4] = mk(0, 0, 0, 0, 0, 0, 2, 0, 1); c[4] = C_JMP; st[4] = S_RUN;
        s[5] = mk(0, 0, 0, 0, 0, 0, 2, 0, 1); c[5] = C_JMP; st[5] = S_FL;
        s[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1); c[6] = C_RUN; st[6] = S_FL;
        s[7] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1); c[7] = C_RUN; st[7] = S_RUN;
        for (int i = 0; i < 8; i++) begin
            drive_push(s[i], c[i], st[i]);
            e = exp_q.pop_front();
            total++;
            if ({w_obs, state, stall_count, flush_count} !== {e.ctl, e.st, e.sc, e.fc}) begin
                bad++;
                $display("[TB] FAIL branch[%0d]: got ctl=%b st=%0d sc=%0d fc=%0d, want ctl=%b st=%0d sc=%0d fc=%0d",
                         i, w_obs, state, stall_count, flush_count, e.ctl, e.st, e.sc, e.fc);
            end
        end
    endtask

    task automatic test_mem_wait();
        stim_t s[9]; logic [8:0] c[9]; logic [1:0] st[9]; exp_t e;
        s[0] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0); c[0] = C_HOLD; st[0] = S_RUN;
        s[1] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0); c[1] = C_HOLD; st[1] = S_MW;
        s[2] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0); c[2] = C_HOLD; st[2] = S_MW;
        s[3] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1); c[3] = C_RUN;  st[3] = S_MW;
        s[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1); c[4] = C_RUN;  st[4] = S_RUN;
        s[5] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0); c[5] = C_HOLD; st[5] = S_RUN;
        s[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); c[6] = C_HOLD; st[6] = S_MW;
        s[7] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1); c[7] = C_RUN;  st[7] = S_MW;
        s[8] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1); c[8] = C_RUN;  st[8] = S_RUN;
        for (int i = 0; i < 9; i++) begin
            drive_push(s[i], c[i], st[i]);
            e = exp_q.pop_front();
            total++;
            if ({w_obs, state, stall_count, flush_count} !== {e.ctl, e.st, e.sc, e.fc}) begin
                bad++;
                $display("[TB] FAIL mem_wait[%0d]: got ctl=%b st=%0d sc=%0d fc=%0d, want ctl=%b st=%0d sc=%0d fc=%0d",
                         i, w_obs, state, stall_count, flush_count, e.ctl, e.st, e.sc, e.fc);
            end
        end
    endtask

    task automatic test_collisions();
        stim_t s[11]; logic [8:0] c[11]; logic [1:0] st[11]; exp_t e;
        s[0]  = mk(3, 0, 0, 3, 1, 1, 1, 0, 1); c[0]  = C_BR;   st[0]  = S_RUN;
        s[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1); c[1]  = C_RUN;  st[1]  = S_FL;
        s[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1); c[2]  = C_RUN;  st[2]  = S_RUN;
        s[3]  = mk(0, 0, 0, 0, 0, 0, 2, 1, 0); c[3]  = C_HOLD; st[3]  = S_RUN;
        s[4]  = mk(0, 0, 0, 0, 0, 0, 2, 1, 0); c[4]  = C_HOLD; st[4]  = S_MW;
        s[5]  = mk(0, 0, 0, 0, 0, 0, 2, 1, 1); c[5]  = C_JMP;  st[5]  = S_MW;
        s[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1); c[6]  = C_RUN;  st[6]  = S_FL;
        s[7]  = mk(4, 0, 0, 4, 1, 1, 0, 1, 0); c[7]  = C_HOLD; st[7]  = S_RUN;
        s[8]  = mk(4, 0, 0, 4, 1, 1, 0, 1, 1); c[8]  = C_LUSE; st[8]  = S_MW;
        s[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1); c[9]  = C_RUN;  st[9]  = S_LS;
        s[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1); c[10] = C_RUN;  st[10] = S_RUN;
        for (int i = 0; i < 11; i++) begin
            drive_push(s[i], c[i], st[i]);
            e = exp_q.pop_front();
            total++;
            if ({w_obs, state, stall_count, flush_count} !== {e.ctl, e.st, e.sc, e.fc}) begin
                bad++;
                $display("[TB] FAIL collide[%0d]: got ctl=%b st=%0d sc=%0d fc=%0d, want ctl=%b st=%0d sc=%0d fc=%0d",
                         i, w_obs, state, stall_count, flush_count, e.ctl, e.st, e.sc, e.fc);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            drive_push(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), C_HOLD, (i == 0) ? S_RUN : S_MW);
            e = exp_q.pop_front();
            total++;
            if ({w_obs, state, stall_count, flush_count} !== {e.ctl, e.st, e.sc, e.fc}) begin
                bad++;
                $display("[TB] FAIL pre_reset[%0d]: got ctl=%b st=%0d sc=%0d fc=%0d, want ctl=%b st=%0d sc=%0d fc=%0d",
                         i, w_obs, state, stall_count, flush_count, e.ctl, e.st, e.sc, e.fc);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({w_obs, state, stall_count, flush_count, s_stall_count} !==
            {C_RST, S_RUN, 16'd0, 16'd0, 4'd0}) begin
            bad++;
            $display("[TB] FAIL reset_mid: got ctl=%b st=%0d sc=%0d fc=%0d sc4=%0d, want ctl=%b st=0 sc=0 fc=0 sc4=0",
                     w_obs, state, stall_count, flush_count, s_stall_count, C_RST);
        end
        m_stall = 0; m_flush = 0; m_stall4 = 0;
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        exp_t e;
        for (int i = 0; i < 20; i++) begin
            drive_push(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), C_HOLD, (i == 0) ? S_RUN : S_MW);
            e = exp_q.pop_front();
            total++;
            if ({w_obs, state, stall_count, flush_count} !== {e.ctl, e.st, e.sc, e.fc}) begin
                bad++;
                $display("[TB] FAIL sat_cycle[%0d]: got ctl=%b st=%0d sc=%0d fc=%0d, want ctl=%b st=%0d sc=%0d fc=%0d",
                         i, w_obs, state, stall_count, flush_count, e.ctl, e.st, e.sc, e.fc);
            end
        end
        drive_push(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), C_RUN, S_MW);
        e = exp_q.pop_front();
        total++;
        if ({stall_count, s_stall_count} !== {e.sc, 4'(m_stall4)}) begin
            bad++;
            $display("[TB] FAIL saturate: got sc=%0d sc4=%0d, want sc=%0d sc4=%0d",
                     stall_count, s_stall_count, e.sc, m_stall4);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_collisions();
        test_reset_mid_run();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
